// File: rtl/keysel_pkg.sv
// keysel_pkg: shared types and constants for the movement-key selector.
// FSM state encoding, HID keycodes for W/A/S/D, present/held mask bit
// positions and the mask-index <-> keycode helpers.
package keysel_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SCAN   = 2'd1,
      ST_UPDATE = 2'd2,
      ST_COMMIT = 2'd3
   } keysel_state_t;

   localparam logic [7:0] KEY_A            = 8'h04;
   localparam logic [7:0] KEY_D            = 8'h07;
   localparam logic [7:0] KEY_S            = 8'h16;
   localparam logic [7:0] KEY_W            = 8'h1A;
   localparam logic [7:0] KEY_NONE         = 8'h00;
   localparam logic [7:0] KEY_ERR_ROLLOVER = 8'h01;

   // Mask bit positions; index order is also the push priority order.
   localparam int IDX_A = 0;
   localparam int IDX_D = 1;
   localparam int IDX_S = 2;
   localparam int IDX_W = 3;

   function automatic logic [7:0] idx_to_key(input logic [1:0] idx);
      case (idx)
         2'd0:    return KEY_A;
         2'd1:    return KEY_D;
         2'd2:    return KEY_S;
         default: return KEY_W;
      endcase
   endfunction

   function automatic logic [3:0] key_to_mask(input logic [7:0] b);
      logic [3:0] m;
      m        = 4'b0000;
      m[IDX_A] = (b == KEY_A);
      m[IDX_D] = (b == KEY_D);
      m[IDX_S] = (b == KEY_S);
      m[IDX_W] = (b == KEY_W);
      return m;
   endfunction

endpackage

// File: rtl/keysel_stack.sv
// keysel_stack: 4-entry last-pressed-wins stack of 2-bit key indices.
// Push appends at the top; remove deletes an entry by value and closes the
// gap so the order of the remaining keys is kept. Each key can appear at
// most once, so a push on a full stack never happens in normal use.
import keysel_pkg::*;

module keysel_stack (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       push_i,
   input  logic       remove_i,
   input  logic [1:0] idx_i,
   output logic [1:0] top,
   output logic       empty
);

   logic [1:0] ent_q [4];
   logic [2:0] cnt_q;
   logic [1:0] rm_pos;
   logic       rm_hit;

   // Locate the live entry holding idx_i (first match from the bottom).
   always_comb begin
      rm_pos = 2'd0;
      rm_hit = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (!rm_hit && (3'(i) < cnt_q) && (ent_q[i] == idx_i)) begin
            rm_pos = 2'(i);
            rm_hit = 1'b1;
         end
      end
   end

   // Stack storage: push at top, or remove-by-value with compaction.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         cnt_q <= 3'd0;
         for (int i = 0; i < 4; i++) ent_q[i] <= 2'd0;
      end else if (push_i) begin
         ent_q[cnt_q[1:0]] <= idx_i;
         cnt_q             <= cnt_q + 3'd1;
      end else if (remove_i && rm_hit) begin
         for (int i = 0; i < 3; i++) begin
            if (2'(i) >= rm_pos) ent_q[i] <= ent_q[i+1];
         end
         cnt_q <= cnt_q - 3'd1;
      end
   end

   assign top   = ent_q[cnt_q[1:0] - 2'd1];
   assign empty = (cnt_q == 3'd0);

   push_on_full_a : assert property (@(posedge Clk) disable iff (Reset)
                                     !(push_i && (cnt_q == 3'd4)));

endmodule

// File: rtl/keycode_select.sv
// keycode_select: picks one W/A/S/D movement key from USB HID reports.
// A report is latched, scanned one slot per cycle into a present mask,
// compared key by key with the held mask to update the selection, and
// committed to `pending`. `keycode` only follows `pending` on a frame_clk
// rising edge so the consumer sees one value per frame.
// Build option KEYSEL_STACK_EN: when defined, a last-pressed-wins stack
// (keysel_stack) falls back to older held keys on release; when undefined a
// single register holds the newest press and is cleared on its release.
// state_o exposes the FSM state for observation.
import keysel_pkg::*;

module keycode_select #(
   parameter int SLOTS = 6
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               frame_clk,
   input  logic               report_valid,
   input  logic [8*SLOTS-1:0] report,
   output logic [7:0]         keycode,
   output logic               busy,
   output logic               overrun,
   output keysel_state_t      state_o
);

   localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
   localparam logic [SW-1:0] LAST_SLOT = SW'(SLOTS - 1);

   keysel_state_t      state_q;
   logic [8*SLOTS-1:0] report_q;
   logic [SW-1:0]      slot_q;
   logic [1:0]         key_q;
   logic [3:0]         present_q;
   logic [3:0]         held_q;
   logic               all_err_q;
   logic               frame_q;
   logic               busy_q;
   logic               overrun_q;
   logic [7:0]         pending_q;
   logic [7:0]         keycode_q;

   logic [7:0]         cur_byte;
   logic [3:0]         byte_mask;
   logic               is_err;
   logic               held_k;
   logic               pres_k;
   logic [7:0]         sel_key;

   assign cur_byte  = report_q[{slot_q, 3'b000} +: 8];
   assign byte_mask = key_to_mask(cur_byte);
   assign is_err    = (cur_byte == KEY_ERR_ROLLOVER);
   assign held_k    = held_q[key_q];
   assign pres_k    = present_q[key_q];

`ifdef KEYSEL_STACK_EN
   logic       do_upd;
   logic       do_push;
   logic       do_remove;
   logic [1:0] stk_top;
   logic       stk_empty;

   assign do_upd    = (state_q == ST_UPDATE);
   assign do_push   = do_upd & pres_k & ~held_k;
   assign do_remove = do_upd & held_k & ~pres_k;

   keysel_stack u_stack (
      .Clk      (Clk),
      .Reset    (Reset),
      .push_i   (do_push),
      .remove_i (do_remove),
      .idx_i    (key_q),
      .top      (stk_top),
      .empty    (stk_empty)
   );

   assign sel_key = stk_empty ? KEY_NONE : idx_to_key(stk_top);
`else
   logic [7:0] sel_q;

   assign sel_key = sel_q;
`endif

   // Report FSM plus frame-edge output register and sticky overrun flag.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= ST_IDLE;
         report_q  <= '0;
         slot_q    <= '0;
         key_q     <= 2'd0;
         present_q <= 4'd0;
         held_q    <= 4'd0;
         all_err_q <= 1'b0;
         frame_q   <= 1'b0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
         pending_q <= KEY_NONE;
         keycode_q <= KEY_NONE;
`ifndef KEYSEL_STACK_EN
         sel_q     <= KEY_NONE;
`endif
      end else begin
         frame_q <= frame_clk;
         // Old pending is presented; a same-cycle commit waits a frame.
         if (frame_clk && !frame_q) keycode_q <= pending_q;
         if (report_valid && (state_q != ST_IDLE)) overrun_q <= 1'b1;

         case (state_q)
            ST_IDLE: begin
               if (report_valid) begin
                  report_q  <= report;
                  present_q <= 4'd0;
                  slot_q    <= '0;
                  all_err_q <= 1'b1;
                  busy_q    <= 1'b1;
                  state_q   <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               present_q <= present_q | byte_mask;
               all_err_q <= all_err_q & is_err;
               if (slot_q == LAST_SLOT) begin
                  if (all_err_q && is_err) begin
                     // ErrorRollOver report: keep previous key state.
                     busy_q  <= 1'b0;
                     state_q <= ST_IDLE;
                  end else begin
                     key_q   <= 2'd0;
                     state_q <= ST_UPDATE;
                  end
               end else begin
                  slot_q <= slot_q + 1'b1;
               end
            end
            ST_UPDATE: begin
`ifndef KEYSEL_STACK_EN
               if (pres_k && !held_k)
                  sel_q <= idx_to_key(key_q);
               else if (held_k && !pres_k && (sel_q == idx_to_key(key_q)))
                  sel_q <= KEY_NONE;
`endif
               if (key_q == 2'd3) state_q <= ST_COMMIT;
               else               key_q   <= key_q + 2'd1;
            end
            ST_COMMIT: begin
               held_q    <= present_q;
               pending_q <= sel_key;
               busy_q    <= 1'b0;
               state_q   <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign keycode = keycode_q;
   assign busy    = busy_q;
   assign overrun = overrun_q;
   assign state_o = state_q;

endmodule
